// File: rtl/sram_io_pkg.sv
// Shared types and constants for the SRAM / memory-mapped I/O bridge.
package sram_io_pkg;

    // Bridge transaction states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    // Wide all-ones pattern; the I/O word sits at the top of the CPU address space
    localparam logic [31:0] IO_ADDR_ALL_ONES = 32'hFFFF_FFFF;

    // Wait-state counter width (covers 0..15 extra cycles)
    localparam int WAIT_CNT_W = 4;

    // Number of byte lanes in a data word
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/sram_io_bridge_if.sv
// CPU-side request/response bus of the SRAM / I/O bridge.
interface sram_io_bridge_if
    import sram_io_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int CPU_ADDR_W = 16
);
    localparam int BE_W = be_width(DATA_W);

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [CPU_ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [BE_W-1:0]       req_be;
    logic                  rsp_valid;
    logic [DATA_W-1:0]     rsp_rdata;

    // CPU datapath side
    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata
    );

    // Bridge side
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata
    );

endinterface

// File: rtl/sram_io_ioregs.sv
// Memory-mapped I/O word: switch read path and byte-lane-masked hex register.
module sram_io_ioregs
    import sram_io_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int NUM_HEX = 4
)(
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        i_wr_en,
    input  logic [be_width(DATA_W)-1:0] i_be,
    input  logic [DATA_W-1:0]           i_wdata,
    input  logic [DATA_W-1:0]           i_switches,
    output logic [DATA_W-1:0]           o_rd_data,
    output logic [4*NUM_HEX-1:0]        o_hex
);
    localparam int BE_W  = be_width(DATA_W);
    localparam int HEX_W = 4 * NUM_HEX;

    logic [HEX_W-1:0]  r_hex;
    logic [HEX_W-1:0]  w_hex_nxt;
    logic [DATA_W-1:0] w_lane_mask;

    // Expand byte enables to a bit mask and merge enabled lanes into the hex value
    always_comb begin
        w_lane_mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            w_lane_mask[8*i +: 8] = {8{i_be[i]}};
        end
        if (i_wr_en) begin
            w_hex_nxt = (r_hex & ~w_lane_mask[HEX_W-1:0]) |
                        (i_wdata[HEX_W-1:0] & w_lane_mask[HEX_W-1:0]);
        end else begin
            w_hex_nxt = r_hex;
        end
    end

    // Hex display register, cleared by reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_hex <= '0;
        end else begin
            r_hex <= w_hex_nxt;
        end
    end

    assign o_hex     = r_hex;
    assign o_rd_data = i_switches;

endmodule

// File: rtl/sram_io_bridge.sv
// CPU request bridge to asynchronous SRAM (programmable wait states, byte
// lanes) and to a single memory-mapped I/O word. All strobes come straight
// from flops so the SRAM pins never glitch.
module sram_io_bridge
    import sram_io_pkg::*;
#(
    parameter int                    DATA_W      = 16,
    parameter int                    CPU_ADDR_W  = 16,
    parameter int                    ADDR_W      = 20,
    parameter int                    WAIT_STATES = 2,
    parameter int                    NUM_HEX     = 4,
    parameter logic [CPU_ADDR_W-1:0] IO_ADDR     = IO_ADDR_ALL_ONES[CPU_ADDR_W-1:0]
)(
    input  logic                        Clk,
    input  logic                        Reset,
    sram_io_bridge_if.slave             bus,
    input  logic [DATA_W-1:0]           Switches,
    output logic [4*NUM_HEX-1:0]        hex_out,
    output logic                        CE_n,
    output logic                        OE_n,
    output logic                        WE_n,
    output logic [be_width(DATA_W)-1:0] BE_n,
    output logic [ADDR_W-1:0]           sram_addr,
    output logic [DATA_W-1:0]           sram_wdata,
    input  logic [DATA_W-1:0]           sram_rdata,
    output logic                        sram_drive
);
    localparam int BE_W = be_width(DATA_W);

    // Expand byte enables into a per-bit mask
    function automatic logic [DATA_W-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_W-1:0] mask;
        mask = '0;
        for (int i = 0; i < BE_W; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    state_t                r_state, w_state_nxt;
    logic [WAIT_CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic                  r_we, w_we_nxt;
    logic [BE_W-1:0]       r_be, w_be_nxt;
    logic [ADDR_W-1:0]     r_sram_addr, w_sram_addr_nxt;
    logic [DATA_W-1:0]     r_wdata, w_wdata_nxt;
    logic [DATA_W-1:0]     r_rdata, w_rdata_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_rsp_valid, w_rsp_valid_nxt;
    logic                  r_ce_n, w_ce_n_nxt;
    logic                  r_oe_n, w_oe_n_nxt;
    logic                  r_we_n, w_we_n_nxt;
    logic [BE_W-1:0]       r_be_n, w_be_n_nxt;
    logic                  r_drive, w_drive_nxt;

    logic                  w_accept;
    logic                  w_hex_wr;
    logic [DATA_W-1:0]     w_io_rdata;

    // Ready is flop-driven but forced low while reset is held
    assign w_accept = (r_state == ST_IDLE) && r_ready && bus.req_valid && Reset;

    // Next-state, latched-request and completion-data logic
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_we_nxt        = r_we;
        w_be_nxt        = r_be;
        w_sram_addr_nxt = r_sram_addr;
        w_wdata_nxt     = r_wdata;
        w_rdata_nxt     = r_rdata;
        w_hex_wr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_we_nxt = bus.req_we;
                    w_be_nxt = bus.req_be;
                    if (bus.req_be == '0) begin
                        w_rdata_nxt = '0;
                        w_state_nxt = ST_RESP;
                    end else if (bus.req_addr == IO_ADDR) begin
                        if (bus.req_we) begin
                            w_hex_wr = 1'b1;
                        end else begin
                            w_rdata_nxt = w_io_rdata;
                        end
                        w_state_nxt = ST_RESP;
                    end else begin
                        w_sram_addr_nxt = ADDR_W'(bus.req_addr);
                        w_wdata_nxt     = bus.req_wdata;
                        w_cnt_nxt       = WAIT_CNT_W'(WAIT_STATES);
                        w_state_nxt     = ST_ACCESS;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == {WAIT_CNT_W{1'b0}}) begin
                    if (r_we) begin
                        w_state_nxt = ST_RECOVER;
                    end else begin
                        // Disabled lanes read as zero
                        w_rdata_nxt = sram_rdata & lane_mask(r_be);
                        w_state_nxt = ST_RESP;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_RECOVER: begin
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming state; strobes follow the state register exactly
    always_comb begin
        w_ready_nxt     = 1'b0;
        w_rsp_valid_nxt = 1'b0;
        w_ce_n_nxt      = 1'b1;
        w_oe_n_nxt      = 1'b1;
        w_we_n_nxt      = 1'b1;
        w_be_n_nxt      = {BE_W{1'b1}};
        w_drive_nxt     = 1'b0;
        case (w_state_nxt)
            ST_IDLE: begin
                w_ready_nxt = 1'b1;
            end
            ST_ACCESS: begin
                w_ce_n_nxt = 1'b0;
                w_be_n_nxt = ~w_be_nxt;
                if (w_we_nxt) begin
                    w_we_n_nxt  = 1'b0;
                    w_drive_nxt = 1'b1;
                end else begin
                    w_oe_n_nxt  = 1'b0;
                end
            end
            ST_RECOVER: begin
                // WE_n released while data is still driven for hold time
                w_ce_n_nxt  = 1'b0;
                w_be_n_nxt  = ~w_be_nxt;
                w_drive_nxt = 1'b1;
            end
            ST_RESP: begin
                w_rsp_valid_nxt = 1'b1;
            end
            default: begin
                w_ready_nxt = 1'b0;
            end
        endcase
    end

    // State, request latches and registered pin outputs
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_be        <= '0;
            r_sram_addr <= '0;
            r_wdata     <= '0;
            r_rdata     <= '0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_be_n      <= {BE_W{1'b1}};
            r_drive     <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_be        <= w_be_nxt;
            r_sram_addr <= w_sram_addr_nxt;
            r_wdata     <= w_wdata_nxt;
            r_rdata     <= w_rdata_nxt;
            r_ready     <= w_ready_nxt;
            r_rsp_valid <= w_rsp_valid_nxt;
            r_ce_n      <= w_ce_n_nxt;
            r_oe_n      <= w_oe_n_nxt;
            r_we_n      <= w_we_n_nxt;
            r_be_n      <= w_be_n_nxt;
            r_drive     <= w_drive_nxt;
        end
    end

    sram_io_ioregs #(
        .DATA_W  (DATA_W),
        .NUM_HEX (NUM_HEX)
    ) u_ioregs (
        .Clk        (Clk),
        .Reset      (Reset),
        .i_wr_en    (w_hex_wr),
        .i_be       (bus.req_be),
        .i_wdata    (bus.req_wdata),
        .i_switches (Switches),
        .o_rd_data  (w_io_rdata),
        .o_hex      (hex_out)
    );

    assign bus.req_ready = r_ready & Reset;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rdata;
    assign CE_n          = r_ce_n;
    assign OE_n          = r_oe_n;
    assign WE_n          = r_we_n;
    assign BE_n          = r_be_n;
    assign sram_addr     = r_sram_addr;
    assign sram_wdata    = r_wdata;
    assign sram_drive    = r_drive;

endmodule

// File: tb/tb_sram_io_bridge.sv
// Directed, table-driven bench for sram_io_bridge (W=2 and W=0 instances).
module tb_sram_io_bridge;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic        Reset;
    logic [15:0] sw;

    sram_io_bridge_if #(.DATA_W(16), .CPU_ADDR_W(16)) bus2 ();
    sram_io_bridge_if #(.DATA_W(16), .CPU_ADDR_W(16)) bus0 ();

    logic [15:0] hex2, hex0, wd2, wd0, rd2, rd0;
    logic        ce2, oe2, we2, drv2, ce0, oe0, we0, drv0;
    logic [1:0]  ben2, ben0;
    logic [19:0] addr2, addr0;

    sram_io_bridge #(.DATA_W(16), .CPU_ADDR_W(16), .ADDR_W(20), .WAIT_STATES(2), .NUM_HEX(4)) u_dut2 (
        .Clk(Clk), .Reset(Reset), .bus(bus2), .Switches(sw), .hex_out(hex2),
        .CE_n(ce2), .OE_n(oe2), .WE_n(we2), .BE_n(ben2), .sram_addr(addr2),
        .sram_wdata(wd2), .sram_rdata(rd2), .sram_drive(drv2)
    );

    sram_io_bridge #(.DATA_W(16), .CPU_ADDR_W(16), .ADDR_W(20), .WAIT_STATES(0), .NUM_HEX(4)) u_dut0 (
        .Clk(Clk), .Reset(Reset), .bus(bus0), .Switches(sw), .hex_out(hex0),
        .CE_n(ce0), .OE_n(oe0), .WE_n(we0), .BE_n(ben0), .sram_addr(addr0),
        .sram_wdata(wd0), .sram_rdata(rd0), .sram_drive(drv0)
    );

    // Behavioural SRAM for the W=2 instance
    logic [15:0] mem [0:255];
    logic [15:0] wmask2;
    assign wmask2 = {{8{~ben2[1]}}, {8{~ben2[0]}}};
    assign rd2    = (!ce2 && !oe2) ? mem[addr2[7:0]] : 16'h0000;
    always @(posedge Clk) begin
        if (!ce2 && !we2 && drv2) mem[addr2[7:0]] <= (mem[addr2[7:0]] & ~wmask2) | (wd2 & wmask2);
    end

    // Fixed read data for the W=0 instance
    logic [15:0] rd0_val;
    assign rd0 = rd0_val;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        int          lat;
        logic [15:0] rdata;
        logic [15:0] hex;
        int          ce_c, oe_c, we_c, drv_c;
        logic [19:0] addr_seen;
        logic [1:0]  ben_seen;
    } res_t;

    typedef struct {
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [15:0] sw;
        int          lat;
        logic        chk_rd;
        logic [15:0] rdata;
        logic [15:0] hex;
        int          ce_c, oe_c, we_c, drv_c;
    } vec_t;

    vec_t vecs [11];

    // One transaction on the W=2 instance; latency counted from the accept edge
    task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                          input logic [1:0] be, output res_t r);
        int waited;
        r.lat = -1; r.rdata = 16'h0; r.hex = 16'h0;
        r.ce_c = 0; r.oe_c = 0; r.we_c = 0; r.drv_c = 0;
        r.addr_seen = 20'h0; r.ben_seen = 2'b00;
        @(negedge Clk);
        bus2.req_valid = 1'b1; bus2.req_we = we; bus2.req_addr = addr;
        bus2.req_wdata = wdata; bus2.req_be = be;
        waited = 0;
        while (!bus2.req_ready && waited < 20) begin
            @(negedge Clk);
            waited++;
        end
        chk("accept_ready", {31'h0, bus2.req_ready}, 32'h1);
        if (!bus2.req_ready) begin
            bus2.req_valid = 1'b0;
            return;
        end
        @(posedge Clk);
        @(negedge Clk);
        bus2.req_valid = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if (!ce2) begin
                if (r.ce_c == 0) begin
                    r.addr_seen = addr2;
                    r.ben_seen  = ben2;
                end
                r.ce_c++;
            end
            if (!ce2 && !oe2) r.oe_c++;
            if (!we2 && drv2) r.we_c++;
            if (drv2) r.drv_c++;
            if (bus2.rsp_valid) begin
                r.lat   = c;
                r.rdata = bus2.rsp_rdata;
                r.hex   = hex2;
                break;
            end
            @(negedge Clk);
        end
    endtask

    initial begin
        res_t        r;
        int          nacc, nrsp, lat0, oe0_c;
        logic [15:0] rdA, rdB, rd0_got;
        logic [19:0] addr0_seen;

        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 2'b11, 16'h0000, 5, 1'b0, 16'h0000, 16'h0000, 4, 0, 3, 4};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 2'b11, 16'h0000, 4, 1'b1, 16'hBEEF, 16'h0000, 3, 3, 0, 0};
        vecs[2]  = '{1'b1, 16'hFFFF, 16'h1234, 2'b01, 16'h0000, 1, 1'b0, 16'h0000, 16'h0034, 0, 0, 0, 0};
        vecs[3]  = '{1'b1, 16'hFFFF, 16'hAB00, 2'b10, 16'h0000, 1, 1'b0, 16'h0000, 16'hAB34, 0, 0, 0, 0};
        vecs[4]  = '{1'b0, 16'hFFFF, 16'h0000, 2'b11, 16'h5A5A, 1, 1'b1, 16'h5A5A, 16'hAB34, 0, 0, 0, 0};
        vecs[5]  = '{1'b1, 16'h0020, 16'h1122, 2'b01, 16'h0000, 5, 1'b0, 16'h0000, 16'hAB34, 4, 0, 3, 4};
        vecs[6]  = '{1'b0, 16'h0020, 16'h0000, 2'b11, 16'h0000, 4, 1'b1, 16'h0022, 16'hAB34, 3, 3, 0, 0};
        vecs[7]  = '{1'b0, 16'h0010, 16'h0000, 2'b10, 16'h0000, 4, 1'b1, 16'hBE00, 16'hAB34, 3, 3, 0, 0};
        vecs[8]  = '{1'b0, 16'h0010, 16'h0000, 2'b00, 16'h0000, 1, 1'b1, 16'h0000, 16'hAB34, 0, 0, 0, 0};
        vecs[9]  = '{1'b0, 16'hFFFF, 16'h0000, 2'b01, 16'h3C3C, 1, 1'b1, 16'h3C3C, 16'hAB34, 0, 0, 0, 0};
        vecs[10] = '{1'b1, 16'hFFFF, 16'h9999, 2'b00, 16'h0000, 1, 1'b1, 16'h0000, 16'hAB34, 0, 0, 0, 0};

        Reset = 1'b0; sw = 16'h0000; rd0_val = 16'hCAFE;
        bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = 16'h0; bus2.req_wdata = 16'h0; bus2.req_be = 2'b00;
        bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = 16'h0; bus0.req_wdata = 16'h0; bus0.req_be = 2'b00;

        // Reset held two cycles: idle values
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        chk("rst_ce_n", {31'h0, ce2}, 32'h1);
        chk("rst_oe_n", {31'h0, oe2}, 32'h1);
        chk("rst_we_n", {31'h0, we2}, 32'h1);
        chk("rst_be_n", {30'h0, ben2}, 32'h3);
        chk("rst_drive", {31'h0, drv2}, 32'h0);
        chk("rst_rsp_valid", {31'h0, bus2.rsp_valid}, 32'h0);
        chk("rst_rsp_rdata", {16'h0, bus2.rsp_rdata}, 32'h0);
        chk("rst_hex", {16'h0, hex2}, 32'h0);
        chk("rst_sram_addr", {12'h0, addr2}, 32'h0);
        chk("rst_ready_low", {31'h0, bus2.req_ready}, 32'h0);
        chk("rst_ce0_n", {31'h0, ce0}, 32'h1);
        Reset = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk("ready_after_release", {31'h0, bus2.req_ready}, 32'h1);
        chk("ready0_after_release", {31'h0, bus0.req_ready}, 32'h1);

        // Table-driven transactions on the W=2 bridge
        for (int i = 0; i < 11; i++) begin
            sw = vecs[i].sw;
            do_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, r);
            chk($sformatf("v%0d_lat", i), r.lat, vecs[i].lat);
            if (vecs[i].chk_rd) chk($sformatf("v%0d_rdata", i), {16'h0, r.rdata}, {16'h0, vecs[i].rdata});
            chk($sformatf("v%0d_hex", i), {16'h0, r.hex}, {16'h0, vecs[i].hex});
            chk($sformatf("v%0d_ce_cycles", i), r.ce_c, vecs[i].ce_c);
            chk($sformatf("v%0d_oe_cycles", i), r.oe_c, vecs[i].oe_c);
            chk($sformatf("v%0d_we_cycles", i), r.we_c, vecs[i].we_c);
            chk($sformatf("v%0d_drive_cycles", i), r.drv_c, vecs[i].drv_c);
            if (vecs[i].ce_c > 0) begin
                chk($sformatf("v%0d_sram_addr", i), {12'h0, r.addr_seen}, {16'h0, vecs[i].addr});
                chk($sformatf("v%0d_be_n", i), {30'h0, r.ben_seen}, {30'h0, ~vecs[i].be});
            end
        end

        // Reset during the second ACCESS cycle of a write
        @(negedge Clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b1; bus2.req_addr = 16'h0030;
        bus2.req_wdata = 16'h5555; bus2.req_be = 2'b11;
        chk("mid_rst_ready", {31'h0, bus2.req_ready}, 32'h1);
        @(posedge Clk);
        @(negedge Clk);
        bus2.req_valid = 1'b0;
        @(negedge Clk);
        chk("mid_rst_we_low_before", {31'h0, we2}, 32'h0);
        Reset = 1'b0;
        @(negedge Clk);
        chk("mid_rst_we_n", {31'h0, we2}, 32'h1);
        chk("mid_rst_ce_n", {31'h0, ce2}, 32'h1);
        chk("mid_rst_drive", {31'h0, drv2}, 32'h0);
        chk("mid_rst_ready_low", {31'h0, bus2.req_ready}, 32'h0);
        chk("mid_rst_hex", {16'h0, hex2}, 32'h0);
        Reset = 1'b1;
        nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (bus2.rsp_valid) nrsp++;
        end
        chk("mid_rst_no_rsp", nrsp, 0);
        chk("mid_rst_rdata", {16'h0, bus2.rsp_rdata}, 32'h0);

        // req_valid held continuously across two back-to-back reads
        @(negedge Clk);
        bus2.req_valid = 1'b1; bus2.req_we = 1'b0; bus2.req_addr = 16'h0010; bus2.req_be = 2'b11;
        nacc = 0; nrsp = 0; rdA = 16'h0; rdB = 16'h0;
        for (int c = 0; c < 40; c++) begin
            if (bus2.rsp_valid) begin
                nrsp++;
                if (nrsp == 1) begin
                    rdA = bus2.rsp_rdata;
                    bus2.req_addr = 16'h0020;
                end else begin
                    rdB = bus2.rsp_rdata;
                    bus2.req_valid = 1'b0;
                end
            end
            if (bus2.req_valid && bus2.req_ready) nacc++;
            @(negedge Clk);
        end
        chk("b2b_accepts", nacc, 2);
        chk("b2b_responses", nrsp, 2);
        chk("b2b_rdata_first", {16'h0, rdA}, 32'h0000BEEF);
        chk("b2b_rdata_second", {16'h0, rdB}, 32'h00000022);

        // W=0 read, upper lane only
        @(negedge Clk);
        bus0.req_valid = 1'b1; bus0.req_we = 1'b0; bus0.req_addr = 16'h0040; bus0.req_be = 2'b10;
        chk("w0_ready", {31'h0, bus0.req_ready}, 32'h1);
        @(posedge Clk);
        @(negedge Clk);
        bus0.req_valid = 1'b0;
        lat0 = -1; oe0_c = 0; rd0_got = 16'h0; addr0_seen = 20'h0;
        for (int c = 1; c <= 10; c++) begin
            if (!oe0) begin
                oe0_c++;
                addr0_seen = addr0;
            end
            if (bus0.rsp_valid) begin
                lat0 = c;
                rd0_got = bus0.rsp_rdata;
                break;
            end
            @(negedge Clk);
        end
        chk("w0_lat", lat0, 2);
        chk("w0_rdata", {16'h0, rd0_got}, 32'h0000CA00);
        chk("w0_oe_cycles", oe0_c, 1);
        chk("w0_sram_addr", {12'h0, addr0_seen}, 32'h00000040);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
